// File: rtl/aste_load_sequencer_if.sv
// Bus bundle for the asteroid load sequencer: level-setup writer, load memory
// port and spawn handshake. master = sequencer side, slave = environment side.
interface aste_load_sequencer_if;
   logic       start;
   logic       abort;
   logic       cfg_we;
   logic [3:0] cfg_addr;
   logic [1:0] cfg_data;
   logic       cfg_ready;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [1:0] mem_data;
   logic [1:0] mem_q;
   logic       spawn_valid;
   logic       spawn_ready;
   logic [3:0] spawn_slot;
   logic       spawn_type;
   logic [4:0] spawn_count;
   logic       busy;
   logic       done;

   modport master (
      input  start, abort, cfg_we, cfg_addr, cfg_data, mem_q, spawn_ready,
      output cfg_ready, mem_we, mem_addr, mem_data, spawn_valid, spawn_slot,
             spawn_type, spawn_count, busy, done
   );

   modport slave (
      output start, abort, cfg_we, cfg_addr, cfg_data, mem_q, spawn_ready,
      input  cfg_ready, mem_we, mem_addr, mem_data, spawn_valid, spawn_slot,
             spawn_type, spawn_count, busy, done
   );
endinterface

// File: rtl/aste_load_sequencer.sv
// Scans the 16 x 2-bit asteroid load memory, emitting one spawn per occupied
// slot with a programmable gap; owns the memory port and grants it to the writer in IDLE.
module aste_load_sequencer #(
   parameter int GAP_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   aste_load_sequencer_if.master bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_EMIT  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   logic [2:0]    state;
   logic [3:0]    idx;
   logic [GW-1:0] gap_cnt;
   logic [3:0]    slot_q;
   logic          type_q;
   logic [4:0]    count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         idx     <= 4'd0;
         gap_cnt <= '0;
         slot_q  <= 4'd0;
         type_q  <= 1'b0;
         count_q <= 5'd0;
      end else if (bus.abort) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state   <= S_READ;
                  idx     <= 4'd0;
                  count_q <= 5'd0;
               end
            end
            S_READ: state <= S_CHECK;
            S_CHECK: begin
               // mem_q here is the data for the address presented during READ
               if (bus.mem_q[1]) begin
                  slot_q <= idx;
                  type_q <= bus.mem_q[0];
                  state  <= S_EMIT;
               end else if (idx == 4'd15) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 4'd1;
                  state <= S_READ;
               end
            end
            S_EMIT: begin
               if (bus.spawn_ready) begin
                  count_q <= count_q + 5'd1;
                  gap_cnt <= '0;
                  if (GAP_CYCLES > 0) begin
                     state <= S_GAP;
                  end else if (idx == 4'd15) begin
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= S_READ;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (idx == 4'd15) begin
                     state <= S_DONE;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= S_READ;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Writer owns the memory port only while idle; otherwise the scan index drives it.
   assign bus.cfg_ready   = (state == S_IDLE);
   assign bus.mem_we      = (state == S_IDLE) && bus.cfg_we;
   assign bus.mem_addr    = (state == S_IDLE) ? bus.cfg_addr : idx;
   assign bus.mem_data    = bus.cfg_data;
   assign bus.spawn_valid = (state == S_EMIT);
   assign bus.spawn_slot  = slot_q;
   assign bus.spawn_type  = type_q;
   assign bus.spawn_count = count_q;
   assign bus.busy        = (state != S_IDLE);
   assign bus.done        = (state == S_DONE);
endmodule

// File: tb/tb_aste_load_sequencer.sv
// Directed bench for aste_load_sequencer: table of scan scenarios plus
// hand-written arbitration, abort and mid-gap reset sequences.
module tb_aste_load_sequencer;
   logic clk;
   logic reset_n;
   int   n_total;
   int   n_pass;

   aste_load_sequencer_if bus ();

   aste_load_sequencer #(.GAP_CYCLES(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // load memory model: synchronous write, one-cycle registered read
   logic [1:0] mem [16];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
      bus.mem_q <= mem[bus.mem_addr];
   end

   typedef struct {
      string       name;
      logic [15:0] occ;
      logic [15:0] typ;
      int          stall;
      logic [15:0] eslots;
      logic [15:0] etypes;
      int          ecount;
      int          edone;
   } vec_t;

   vec_t tv[6];

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic load(input logic [15:0] occ, input logic [15:0] typ);
      for (int i = 0; i < 16; i++) begin
         bus.cfg_we   = 1'b1;
         bus.cfg_addr = 4'(i);
         bus.cfg_data = {occ[i], typ[i]};
         @(posedge clk); #1;
      end
      bus.cfg_we = 1'b0;
   endtask

   task automatic kick();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // start pulse at edge E0; sample #1 after each edge as cycle E0+cyc
   task automatic do_scan(input string name, input logic [15:0] eslots,
                          input logic [15:0] etypes, input int ecount,
                          input int edone, input int stall);
      int cyc, ptr, got, ndone, dcyc, waited;
      cyc = 1; ptr = 0; got = 0; ndone = 0; dcyc = -1; waited = 0;
      bus.start = 1'b1;
      bus.spawn_ready = 1'b1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      chk({name, ".busy_c1"}, bus.busy, 1);
      chk({name, ".cfg_ready_c1"}, bus.cfg_ready, 0);
      while (cyc < 400) begin
         if (bus.spawn_valid) begin
            while (ptr < 16 && !eslots[ptr]) ptr++;
            chk({name, ".slot"}, bus.spawn_slot, ptr);
            if (got == 0 && waited < stall) begin
               bus.spawn_ready = 1'b0;
               waited++;
            end else begin
               bus.spawn_ready = 1'b1;
               if (ptr < 16) chk({name, ".type"}, bus.spawn_type, etypes[ptr]);
               got++;
               ptr++;
            end
         end else begin
            bus.spawn_ready = 1'b1;
         end
         if (bus.done) begin
            ndone++;
            dcyc = cyc;
         end
         if (ndone > 0 && !bus.busy) break;
         @(posedge clk); #1;
         cyc++;
      end
      if (ndone == 0) $display("FAIL %s.timeout: got no done within %0d cycles expected done", name, cyc);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      chk({name, ".done_cycle"}, dcyc, edone);
      chk({name, ".done_pulses"}, ndone, 1);
      chk({name, ".accepted"}, got, ecount);
      chk({name, ".spawn_count"}, bus.spawn_count, ecount);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      for (int i = 0; i < 16; i++) mem[i] = 2'b00;
      bus.start = 0; bus.abort = 0; bus.cfg_we = 0; bus.cfg_addr = 0;
      bus.cfg_data = 0; bus.spawn_ready = 1;

      tv[0] = '{"full",    16'hFE73, 16'h0000, 0, 16'hFE73, 16'h0000, 12, 93};
      tv[1] = '{"bp",      16'hFE73, 16'h0000, 5, 16'hFE73, 16'h0000, 12, 98};
      tv[2] = '{"empty",   16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0,  33};
      tv[3] = '{"slot2t1", 16'h0004, 16'h0004, 0, 16'h0004, 16'h0004, 1,  38};
      tv[4] = '{"allocc",  16'hFFFF, 16'hAAAA, 0, 16'hFFFF, 16'hAAAA, 16, 113};
      tv[5] = '{"last",    16'h8000, 16'h8000, 2, 16'h8000, 16'h8000, 1,  40};

      // reset values; mem_we follows cfg_we while held in reset (IDLE)
      reset_n = 1'b0;
      bus.cfg_we = 1'b1;
      #12;
      chk("rst.mem_we", bus.mem_we, 1);
      chk("rst.cfg_ready", bus.cfg_ready, 1);
      chk("rst.busy", bus.busy, 0);
      chk("rst.spawn_valid", bus.spawn_valid, 0);
      chk("rst.done", bus.done, 0);
      chk("rst.spawn_count", bus.spawn_count, 0);
      chk("rst.spawn_slot", bus.spawn_slot, 0);
      chk("rst.spawn_type", bus.spawn_type, 0);
      bus.cfg_we = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      for (int r = 0; r < 6; r++) begin
         load(tv[r].occ, tv[r].typ);
         do_scan(tv[r].name, tv[r].eslots, tv[r].etypes, tv[r].ecount, tv[r].edone, tv[r].stall);
      end

      // arbitration: writer stalled while busy, then write slot 2 = 11 with start
      load(16'h0000, 16'h0000);
      kick();
      @(posedge clk); #1;
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'd2; bus.cfg_data = 2'b11;
      #1;
      chk("arb.mem_we_busy", bus.mem_we, 0);
      chk("arb.cfg_ready_busy", bus.cfg_ready, 0);
      begin
         int w;
         w = 0;
         while (w < 60) begin
            @(posedge clk); #1;
            w++;
            if (bus.cfg_ready) break;
            if (bus.mem_we) $display("FAIL arb.mem_we_leak: got 1 expected 0 at wait %0d", w);
         end
         chk("arb.grant_seen", bus.cfg_ready, 1);
         chk("arb.mem_we_grant", bus.mem_we, 1);
      end
      do_scan("arb_scan", 16'h0004, 16'h0004, 1, 38, 0);

      // abort while slot 4 is pending in EMIT
      load(16'h0010, 16'h0000);
      bus.spawn_ready = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      begin
         int w;
         w = 0;
         while (!bus.spawn_valid && w < 40) begin
            bus.spawn_ready = 1'b0;
            @(posedge clk); #1;
            w++;
         end
      end
      chk("abort.reached_emit", bus.spawn_valid, 1);
      chk("abort.slot", bus.spawn_slot, 4);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      chk("abort.spawn_valid", bus.spawn_valid, 0);
      chk("abort.busy", bus.busy, 0);
      chk("abort.cfg_ready", bus.cfg_ready, 1);
      chk("abort.spawn_count", bus.spawn_count, 0);
      begin
         int nd;
         nd = bus.done ? 1 : 0;
         for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus.done) nd++;
         end
         chk("abort.no_done", nd, 0);
      end
      bus.spawn_ready = 1'b1;

      // reset asserted while in GAP after the slot 0 spawn
      load(16'h0001, 16'h0001);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      begin
         int w;
         w = 0;
         while (!bus.spawn_valid && w < 40) begin
            @(posedge clk); #1;
            w++;
         end
      end
      chk("rgap.spawn_type", bus.spawn_type, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rgap.count_before", bus.spawn_count, 1);
      reset_n = 1'b0;
      #1;
      chk("rgap.busy", bus.busy, 0);
      chk("rgap.spawn_valid", bus.spawn_valid, 0);
      chk("rgap.done", bus.done, 0);
      chk("rgap.cfg_ready", bus.cfg_ready, 1);
      chk("rgap.spawn_count", bus.spawn_count, 0);
      chk("rgap.spawn_type0", bus.spawn_type, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      do_scan("rescan", 16'h0001, 16'h0001, 1, 38, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
